// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: resolves decode read ports against EX, MEM and a
// short writeback history, and raises a counted stall when a read depends on a load in EX.
module fwd_hazard_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned WB_DEPTH   = 2,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ*REG_ADDR_W-1:0] rs_addr_cu,
  input  logic [NUM_READ-1:0]            read_en_cu,
  input  logic [REG_ADDR_W-1:0]          rd_ex,
  input  logic [DATA_W-1:0]              value_ex,
  input  logic                           register_write_ex,
  input  logic                           load_ex,
  input  logic [REG_ADDR_W-1:0]          rd_mem,
  input  logic [DATA_W-1:0]              value_mem,
  input  logic                           register_write_mem,
  input  logic [REG_ADDR_W-1:0]          rd_wb,
  input  logic [DATA_W-1:0]              value_wb,
  input  logic                           register_write_wb,
  input  logic                           flush,
  output logic [NUM_READ-1:0]            forwarding,
  output logic [NUM_READ*DATA_W-1:0]     value_fwd,
  output logic                           stall
);

  localparam int unsigned CNT_W = $clog2(LOAD_LAT + 1);

  typedef enum logic {
    IDLE     = 1'b0,
    STALLING = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WB_DEPTH-1:0]   hist_vld_q, hist_vld_d;
  logic [REG_ADDR_W-1:0] hist_rd_q  [WB_DEPTH];
  logic [REG_ADDR_W-1:0] hist_rd_d  [WB_DEPTH];
  logic [DATA_W-1:0]     hist_val_q [WB_DEPTH];
  logic [DATA_W-1:0]     hist_val_d [WB_DEPTH];

  logic                  hazard_c;
  logic [REG_ADDR_W-1:0] rs_c;
  logic                  hist_hit_c;
  logic [DATA_W-1:0]     hist_val_c;

  // Writeback history: entry 0 is newest, the oldest falls off the end
  always_comb begin
    hist_vld_d[0] = register_write_wb && (rd_wb != '0);
    hist_rd_d[0]  = rd_wb;
    hist_val_d[0] = value_wb;
    for (int i = 1; i < int'(WB_DEPTH); i++) begin
      hist_vld_d[i] = hist_vld_q[i-1];
      hist_rd_d[i]  = hist_rd_q[i-1];
      hist_val_d[i] = hist_val_q[i-1];
    end
  end

  // Per-port source selection; a matching load in EX blocks older (stale) sources
  always_comb begin
    forwarding = '0;
    value_fwd  = '0;
    hazard_c   = 1'b0;
    rs_c       = '0;
    hist_hit_c = 1'b0;
    hist_val_c = '0;
    for (int k = 0; k < int'(NUM_READ); k++) begin
      rs_c       = rs_addr_cu[k*REG_ADDR_W +: REG_ADDR_W];
      hist_hit_c = 1'b0;
      hist_val_c = '0;
      for (int i = int'(WB_DEPTH) - 1; i >= 0; i--) begin
        if (!rst && hist_vld_q[i] && (hist_rd_q[i] == rs_c)) begin
          hist_hit_c = 1'b1;
          hist_val_c = hist_val_q[i];
        end
      end
      if (read_en_cu[k] && (rs_c != '0)) begin
        if (register_write_ex && (rd_ex == rs_c)) begin
          if (load_ex) begin
            hazard_c = 1'b1;
          end else begin
            forwarding[k]                   = 1'b1;
            value_fwd[k*DATA_W +: DATA_W] = value_ex;
          end
        end else if (register_write_mem && (rd_mem == rs_c)) begin
          forwarding[k]                   = 1'b1;
          value_fwd[k*DATA_W +: DATA_W] = value_mem;
        end else if (hist_hit_c) begin
          forwarding[k]                   = 1'b1;
          value_fwd[k*DATA_W +: DATA_W] = hist_val_c;
        end
      end
    end
  end

  // Stall FSM: first stall cycle is combinational from IDLE, the rest are counted out
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (rst || flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hazard_c) begin
            stall = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = STALLING;
              cnt_d   = CNT_W'(LOAD_LAT - 1);
            end
          end
        end
        STALLING: begin
          stall = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hist_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hist_vld_q <= hist_vld_d;
    end
    hist_rd_q  <= hist_rd_d;
    hist_val_q <= hist_val_d;
  end

endmodule
